// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step decoder: FSM state encoding and the
// Gray-to-binary conversion used by the RTL and by test benches.
package gray_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_TRACK = 1'b1;

  localparam int GRAY_MAX_W = 16;

  // Prefix XOR from the MSB down; only the low 'width' bits are converted.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int                    width
  );
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Combinational Gray-to-binary converter, WIDTH up to 16 bits.
module gray_to_bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [GRAY_MAX_W-1:0] bin_full;

  assign bin_full = gray_to_bin(GRAY_MAX_W'(gray), WIDTH);
  assign bin      = bin_full[WIDTH-1:0];

endmodule

// File: rtl/gray_step_decoder.sv
// Gray-coded stream receiver: converts to binary, classifies each step as
// up/down/error, and registers the result behind a valid/ready stage.
// Optional GRAY_STEP_DECODER_ONEHOT_EN adds a registered one-hot copy of bin_out.
//
//   state    | meaning
//   ST_IDLE  | no reference word yet; next accepted word only seeds prev
//   ST_TRACK | prev holds the last accepted word; steps are classified
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       gray_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       bin_out,
  output logic                   step_up,
  output logic                   step_dn,
  output logic                   step_err,
  output logic [ERR_W-1:0]       err_count,
  input  logic                   clear
`ifdef GRAY_STEP_DECODER_ONEHOT_EN
  ,
  output logic [2**WIDTH-1:0]    onehot_out
`endif
);

  logic             state_q;
  logic             state_d;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             up_d;
  logic             dn_d;
  logic             err_d;

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_conv (
    .gray (gray_in),
    .bin  (bin_c)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign diff     = bin_c - prev_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A clear coinciding with an accept processes that word as a first word,
  // so the machine still ends up tracking from it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_TRACK;
    end else if (clear) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    up_d  = 1'b0;
    dn_d  = 1'b0;
    err_d = 1'b0;
    if (state_q == ST_TRACK && !clear) begin
      if (diff == WIDTH'(1)) begin
        up_d = 1'b1;
      end else if (diff == {WIDTH{1'b1}}) begin
        dn_d = 1'b1;
      end else if (diff != '0) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q    <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        prev_q <= bin_c;
      end
      if (clear) begin
        err_count <= '0;
      end else if (accept && err_d && err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      step_err  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bin_out   <= bin_c;
      step_up   <= up_d;
      step_dn   <= dn_d;
      step_err  <= err_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_STEP_DECODER_ONEHOT_EN
  localparam logic [2**WIDTH-1:0] ONEHOT_LSB = {{(2**WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      onehot_out <= '0;
    end else if (accept) begin
      onehot_out <= ONEHOT_LSB << bin_c;
    end
  end
`endif

endmodule
